// File: rtl/regfile_rename_pkg.sv
// Shared widths and constants for the rename register file slice.
// COMMIT_BYPASS_EN (in rtl/regfile_rename_rf_read_port.sv) selects same-cycle commit forwarding.
package regfile_rename_pkg;
   localparam int REG_WIDTH = 5;
   localparam int VAL_WIDTH = 32;
   localparam int ID_WIDTH  = 5;
   // Label value meaning "no pending producer, register value is valid".
   localparam logic [ID_WIDTH-1:0] LABEL_READY = '0;
endpackage

// File: rtl/regfile_rename_if.sv
// Issue/read/commit bus between the ROB/decoder side (master) and the register file (slave).
// Every field is a qualified strobe plus payload. No backpressure: the file accepts each strobe in the cycle it is raised.
interface regfile_rename_if
   import regfile_rename_pkg::*;
#(
   parameter int ID_W  = ID_WIDTH,
   parameter int VAL_W = VAL_WIDTH
) ();
   logic                 iss_en;
   logic [REG_WIDTH-1:0] iss_rd;
   logic [ID_W-1:0]      iss_tag;
   logic [REG_WIDTH-1:0] rs1_idx;
   logic [REG_WIDTH-1:0] rs2_idx;
   logic [ID_W-1:0]      rs1_label;
   logic [ID_W-1:0]      rs2_label;
   logic [VAL_W-1:0]     rs1_val;
   logic [VAL_W-1:0]     rs2_val;
   logic                 cmt_en;
   logic [REG_WIDTH-1:0] cmt_rd;
   logic [VAL_W-1:0]     cmt_val;
   logic [ID_W-1:0]      cmt_tag;

   modport master (
      output iss_en, iss_rd, iss_tag, rs1_idx, rs2_idx,
      output cmt_en, cmt_rd, cmt_val, cmt_tag,
      input  rs1_label, rs2_label, rs1_val, rs2_val
   );

   modport slave (
      input  iss_en, iss_rd, iss_tag, rs1_idx, rs2_idx,
      input  cmt_en, cmt_rd, cmt_val, cmt_tag,
      output rs1_label, rs2_label, rs1_val, rs2_val
   );
endinterface

// File: rtl/regfile_rename_rf_read_port.sv
// Combinational operand read port: x0 forcing plus optional commit forwarding.
// Forwarding is enabled by defining COMMIT_BYPASS_EN.
module rf_read_port
   import regfile_rename_pkg::*;
#(
   parameter int NREG  = 32,
   parameter int ID_W  = ID_WIDTH,
   parameter int VAL_W = VAL_WIDTH
) (
   input  logic [REG_WIDTH-1:0] idx,
   input  logic [VAL_W-1:0]     vals   [NREG],
   input  logic [ID_W-1:0]      labels [NREG],
   input  logic                 rdy,
   input  logic                 cmt_en,
   input  logic [REG_WIDTH-1:0] cmt_rd,
   input  logic [VAL_W-1:0]     cmt_val,
   input  logic [ID_W-1:0]      cmt_tag,
   output logic [ID_W-1:0]      label,
   output logic [VAL_W-1:0]     val
);

   always_comb begin
      label = ID_W'(LABEL_READY);
      val   = '0;
      if (idx != '0) begin
         label = labels[idx];
         val   = vals[idx];
`ifdef COMMIT_BYPASS_EN
         // Only the tag that still owns the register may resolve the operand early.
         if (rdy && cmt_en && (cmt_rd == idx) && (labels[idx] == cmt_tag)) begin
            label = ID_W'(LABEL_READY);
            val   = cmt_val;
         end
`endif
      end
   end

`ifndef COMMIT_BYPASS_EN
   logic unused_cmt;
   assign unused_cmt = ^{rdy, cmt_en, cmt_rd, cmt_val, cmt_tag};
`endif

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename labels (x0 hardwired to zero).
// Optional same-cycle commit forwarding on reads: define COMMIT_BYPASS_EN.
module regfile_rename
   import regfile_rename_pkg::*;
#(
   parameter int NREG  = 32,
   parameter int ID_W  = ID_WIDTH,
   parameter int VAL_W = VAL_WIDTH
) (
   input  logic             clk,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             flush_in,
   regfile_rename_if.slave  bus
);

   logic [VAL_W-1:0] vals   [NREG];
   logic [ID_W-1:0]  labels [NREG];

   logic iss_fire;
   logic cmt_fire;
   logic cmt_owns;

   assign iss_fire = rdy_in && bus.iss_en && !flush_in && (bus.iss_rd != '0);
   assign cmt_fire = rdy_in && bus.cmt_en && (bus.cmt_rd != '0);
   assign cmt_owns = (labels[bus.cmt_rd] == bus.cmt_tag);

   // Statement order encodes priority: flush clears, commit releases its own tag,
   // and a same-cycle issue overrides both for its destination.
   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < NREG; i++) begin
            vals[i]   <= '0;
            labels[i] <= ID_W'(LABEL_READY);
         end
      end else if (rdy_in) begin
         if (flush_in) begin
            for (int i = 0; i < NREG; i++) begin
               labels[i] <= ID_W'(LABEL_READY);
            end
         end
         if (cmt_fire) begin
            vals[bus.cmt_rd] <= bus.cmt_val;
            if (cmt_owns) begin
               labels[bus.cmt_rd] <= ID_W'(LABEL_READY);
            end
         end
         if (iss_fire) begin
            labels[bus.iss_rd] <= bus.iss_tag;
         end
      end
   end

   rf_read_port #(.NREG(NREG), .ID_W(ID_W), .VAL_W(VAL_W)) u_rd1 (
      .idx     (bus.rs1_idx),
      .vals    (vals),
      .labels  (labels),
      .rdy     (rdy_in),
      .cmt_en  (bus.cmt_en),
      .cmt_rd  (bus.cmt_rd),
      .cmt_val (bus.cmt_val),
      .cmt_tag (bus.cmt_tag),
      .label   (bus.rs1_label),
      .val     (bus.rs1_val)
   );

   rf_read_port #(.NREG(NREG), .ID_W(ID_W), .VAL_W(VAL_W)) u_rd2 (
      .idx     (bus.rs2_idx),
      .vals    (vals),
      .labels  (labels),
      .rdy     (rdy_in),
      .cmt_en  (bus.cmt_en),
      .cmt_rd  (bus.cmt_rd),
      .cmt_val (bus.cmt_val),
      .cmt_tag (bus.cmt_tag),
      .label   (bus.rs2_label),
      .val     (bus.rs2_val)
   );

endmodule

// File: tb/tb_regfile_rename.sv
// Directed bench for regfile_rename: an array model is checked against every read each cycle,
// and hand-computed literals pin the model at key points.
module tb_regfile_rename;

   logic clk      = 1'b0;
   logic rst_in   = 1'b1;
   logic rdy_in   = 1'b1;
   logic flush_in = 1'b0;
   logic started  = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   regfile_rename_if #(.ID_W(5), .VAL_W(32)) bus ();

   regfile_rename #(.NREG(32), .ID_W(5), .VAL_W(32)) dut (
      .clk      (clk),
      .rst_in   (rst_in),
      .rdy_in   (rdy_in),
      .flush_in (flush_in),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // ---------------- model ----------------
   logic [31:0] m_val   [32];
   logic [4:0]  m_label [32];

   always @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         for (int r = 0; r < 32; r++) begin
            m_val[r]   = 32'h0;
            m_label[r] = 5'h0;
         end
      end else if (rdy_in) begin
         logic [4:0] old_label [32];
         for (int r = 0; r < 32; r++) old_label[r] = m_label[r];
         for (int r = 1; r < 32; r++) begin
            logic committing, issuing;
            committing = bus.cmt_en && (bus.cmt_rd == 5'(r));
            issuing    = bus.iss_en && !flush_in && (bus.iss_rd == 5'(r));
            if (committing) m_val[r] = bus.cmt_val;
            if (issuing)                                          m_label[r] = bus.iss_tag;
            else if (flush_in)                                    m_label[r] = 5'h0;
            else if (committing && old_label[r] == bus.cmt_tag)   m_label[r] = 5'h0;
         end
      end
   end

   function automatic logic [4:0] exp_label(input logic [4:0] idx);
      if (idx == 5'd0) return 5'h0;
`ifdef COMMIT_BYPASS_EN
      if (rdy_in && bus.cmt_en && bus.cmt_rd == idx && m_label[idx] == bus.cmt_tag) return 5'h0;
`endif
      return m_label[idx];
   endfunction

   function automatic logic [31:0] exp_val(input logic [4:0] idx);
      if (idx == 5'd0) return 32'h0;
`ifdef COMMIT_BYPASS_EN
      if (rdy_in && bus.cmt_en && bus.cmt_rd == idx && m_label[idx] == bus.cmt_tag) return bus.cmt_val;
`endif
      return m_val[idx];
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      #1;
      if (started && !rst_in) begin
         check("cmp_rs1_label", 32'(bus.rs1_label), 32'(exp_label(bus.rs1_idx)));
         check("cmp_rs1_val",   bus.rs1_val,        exp_val(bus.rs1_idx));
         check("cmp_rs2_label", 32'(bus.rs2_label), 32'(exp_label(bus.rs2_idx)));
         check("cmp_rs2_val",   bus.rs2_val,        exp_val(bus.rs2_idx));
      end
   end

   // ---------------- driver ----------------
   task automatic apply(input logic ie, input logic [4:0] ird, input logic [4:0] itag,
                        input logic ce, input logic [4:0] crd, input logic [4:0] ctag,
                        input logic [31:0] cval, input logic fl,
                        input logic [4:0] r1, input logic [4:0] r2, input logic rdy);
      @(negedge clk);
      bus.iss_en  = ie;
      bus.iss_rd  = ird;
      bus.iss_tag = itag;
      bus.cmt_en  = ce;
      bus.cmt_rd  = crd;
      bus.cmt_tag = ctag;
      bus.cmt_val = cval;
      flush_in    = fl;
      bus.rs1_idx = r1;
      bus.rs2_idx = r2;
      rdy_in      = rdy;
   endtask

   task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
      apply(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, r1, r2, 1'b1);
   endtask

   task automatic issue(input logic [4:0] rd, input logic [4:0] tag, input logic [4:0] r1);
      apply(1'b1, rd, tag, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, r1, 5'd0, 1'b1);
   endtask

   task automatic commit(input logic [4:0] rd, input logic [4:0] tag, input logic [31:0] v,
                         input logic [4:0] r1);
      apply(1'b0, 5'd0, 5'd0, 1'b1, rd, tag, v, 1'b0, r1, 5'd0, 1'b1);
   endtask

   initial begin
      bus.iss_en = 1'b0; bus.iss_rd = '0; bus.iss_tag = '0;
      bus.cmt_en = 1'b0; bus.cmt_rd = '0; bus.cmt_tag = '0; bus.cmt_val = '0;
      bus.rs1_idx = '0; bus.rs2_idx = '0;

      // reset held across two edges
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_in  = 1'b0;
      started = 1'b1;
      idle(5'd5, 5'd31);
      #1;
      check("reset_rs1_label", 32'(bus.rs1_label), 32'h0);
      check("reset_rs2_val",   bus.rs2_val,        32'h0);

      // issue x5 tag 3, then commit it
      issue(5'd5, 5'd3, 5'd5);
      idle(5'd5, 5'd0);
      #1 check("iss_x5_label", 32'(bus.rs1_label), 32'd3);
      commit(5'd5, 5'd3, 32'hDEAD, 5'd5);
      idle(5'd5, 5'd0);
      #1;
      check("cmt_x5_label", 32'(bus.rs1_label), 32'd0);
      check("cmt_x5_val",   bus.rs1_val,        32'hDEAD);

      // younger producer keeps its label
      issue(5'd5, 5'd3, 5'd5);
      issue(5'd5, 5'd4, 5'd5);
      commit(5'd5, 5'd3, 32'd7, 5'd5);
      idle(5'd5, 5'd0);
      #1;
      check("young_x5_label", 32'(bus.rs1_label), 32'd4);
      check("young_x5_val",   bus.rs1_val,        32'd7);

      // same-cycle issue + commit on x6
      issue(5'd6, 5'd1, 5'd0);
      apply(1'b1, 5'd6, 5'd2, 1'b1, 5'd6, 5'd1, 32'd9, 1'b0, 5'd0, 5'd6, 1'b1);
      idle(5'd0, 5'd6);
      #1;
      check("same_x6_label", 32'(bus.rs2_label), 32'd2);
      check("same_x6_val",   bus.rs2_val,        32'd9);

      // flush with commit to x1 and a dropped issue to x4
      issue(5'd1, 5'd1, 5'd0);
      issue(5'd2, 5'd2, 5'd0);
      issue(5'd3, 5'd3, 5'd0);
      apply(1'b1, 5'd4, 5'd5, 1'b1, 5'd1, 5'd7, 32'h11, 1'b1, 5'd1, 5'd4, 1'b1);
      idle(5'd1, 5'd4);
      #1;
      check("flush_x1_label", 32'(bus.rs1_label), 32'd0);
      check("flush_x1_val",   bus.rs1_val,        32'h11);
      check("flush_x4_label", 32'(bus.rs2_label), 32'd0);
      idle(5'd2, 5'd3);
      #1;
      check("flush_x2_label", 32'(bus.rs1_label), 32'd0);
      check("flush_x3_label", 32'(bus.rs2_label), 32'd0);

      // x0 writes ignored
      apply(1'b1, 5'd0, 5'd5, 1'b1, 5'd0, 5'd5, 32'h55, 1'b0, 5'd0, 5'd0, 1'b1);
      idle(5'd0, 5'd0);
      #1;
      check("x0_label", 32'(bus.rs1_label), 32'd0);
      check("x0_val",   bus.rs1_val,        32'd0);

      // rdy_in low holds everything
      issue(5'd9, 5'd6, 5'd9);
      apply(1'b1, 5'd8, 5'd6, 1'b1, 5'd5, 5'd0, 32'h99, 1'b1, 5'd8, 5'd5, 1'b0);
      idle(5'd8, 5'd5);
      #1;
      check("hold_x8_label", 32'(bus.rs1_label), 32'd0);
      check("hold_x5_val",   bus.rs2_val,        32'd7);
      idle(5'd9, 5'd0);
      #1 check("hold_x9_label", 32'(bus.rs1_label), 32'd6);

      // commit to x7 while reading it
      issue(5'd7, 5'd2, 5'd7);
      commit(5'd7, 5'd2, 32'd5, 5'd7);
      #1;
`ifdef COMMIT_BYPASS_EN
      check("byp_x7_label", 32'(bus.rs1_label), 32'd0);
      check("byp_x7_val",   bus.rs1_val,        32'd5);
`else
      check("nobyp_x7_label", 32'(bus.rs1_label), 32'd2);
      check("nobyp_x7_val",   bus.rs1_val,        32'd0);
`endif
      idle(5'd7, 5'd0);
      #1 check("after_x7_val", bus.rs1_val, 32'd5);

      // asynchronous reset between edges
      issue(5'd5, 5'd3, 5'd5);
      idle(5'd5, 5'd7);
      #1 check("pre_rst_x5_label", 32'(bus.rs1_label), 32'd3);
      #1 rst_in = 1'b1;
      #1;
      check("async_rst_x5_label", 32'(bus.rs1_label), 32'd0);
      check("async_rst_x5_val",   bus.rs1_val,        32'd0);
      check("async_rst_x7_val",   bus.rs2_val,        32'd0);
      #1 rst_in = 1'b0;
      idle(5'd5, 5'd7);
      idle(5'd1, 5'd6);
      @(negedge clk);
      #2;
      started = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
